// File: rtl/reorder_buffer_if.sv
// Issue, CDB, operand-query, commit and flush signals of the reorder buffer.
// The pipeline side uses the master modport; the reorder buffer uses slave.
interface reorder_buffer_if #(
    parameter int ENTRY_SIZE = 4
);
    logic                  rdy;

    logic                  issue_valid;
    logic                  issue_ready;
    logic                  issue_has_rd;
    logic [4:0]            issue_rd;
    logic                  issue_is_branch;
    logic [ENTRY_SIZE-1:0] issue_tag;

    logic                  set_reorder;
    logic [4:0]            set_reorder_number;
    logic [ENTRY_SIZE-1:0] set_reorder_entry;

    logic                  cdb_valid;
    logic [ENTRY_SIZE-1:0] cdb_tag;
    logic [31:0]           cdb_value;
    logic                  cdb_mispredict;
    logic [31:0]           cdb_target;

    logic [ENTRY_SIZE-1:0] query_tag;
    logic                  query_ready;
    logic [31:0]           query_value;

    logic                  write_enable;
    logic [4:0]            write_addr;
    logic [31:0]           write_data;
    logic [ENTRY_SIZE-1:0] commit_tag;

    logic                  flush;
    logic [31:0]           flush_pc;

    modport master (
        output rdy, issue_valid, issue_has_rd, issue_rd, issue_is_branch,
               cdb_valid, cdb_tag, cdb_value, cdb_mispredict, cdb_target, query_tag,
        input  issue_ready, issue_tag, set_reorder, set_reorder_number, set_reorder_entry,
               query_ready, query_value, write_enable, write_addr, write_data, commit_tag,
               flush, flush_pc
    );

    modport slave (
        input  rdy, issue_valid, issue_has_rd, issue_rd, issue_is_branch,
               cdb_valid, cdb_tag, cdb_value, cdb_mispredict, cdb_target, query_tag,
        output issue_ready, issue_tag, set_reorder, set_reorder_number, set_reorder_entry,
               query_ready, query_value, write_enable, write_addr, write_data, commit_tag,
               flush, flush_pc
    );
endinterface

// File: rtl/reorder_buffer.sv
// Circular in-order retirement queue. Issue allocates at tail, the CDB marks
// entries complete, and the head retires in program order: a normal commit
// writes the register file, a mispredicted branch flushes the whole buffer.
module reorder_buffer #(
    parameter int ROB_SIZE   = 16,
    parameter int ENTRY_SIZE = 4
) (
    input  logic            clk,
    input  logic            rst,
    reorder_buffer_if.slave rob
);
    localparam logic [ENTRY_SIZE:0]   FULL    = (ENTRY_SIZE+1)'(ROB_SIZE);
    localparam logic [ENTRY_SIZE-1:0] PTR_ONE = ENTRY_SIZE'(1);
    localparam logic [ENTRY_SIZE:0]   CNT_ONE = (ENTRY_SIZE+1)'(1);

    // Control state: every bit here is reset.
    logic [ROB_SIZE-1:0]   busy;
    logic [ROB_SIZE-1:0]   ready;
    logic [ENTRY_SIZE-1:0] head;
    logic [ENTRY_SIZE-1:0] tail;
    logic [ENTRY_SIZE:0]   count;

    // Payload: only ever read through a busy (and, for results, ready) entry.
    logic [ROB_SIZE-1:0]   has_rd;
    logic [ROB_SIZE-1:0]   is_branch;
    logic [ROB_SIZE-1:0]   mispredict;
    logic [4:0]            rd     [ROB_SIZE];
    logic [31:0]           value  [ROB_SIZE];
    logic [31:0]           target [ROB_SIZE];

    logic commit_fire;
    logic commit_flush;
    logic issue_ok;
    logic fire;
    logic cdb_accept;

    // Per-cycle decisions: commit, flush, issue acceptance and CDB acceptance.
    // NOTE: combinational blocks use blocking '=' so later lines see the values
    // computed above them; clocked blocks use '<=' so every flop samples pre-edge values.
    always_comb begin
        commit_fire  = rob.rdy && (count != '0) && busy[head] && ready[head];
        commit_flush = commit_fire && is_branch[head] && mispredict[head];
        issue_ok     = rob.rdy && (count != FULL) && !commit_flush;
        fire         = rob.issue_valid && issue_ok;
        cdb_accept   = rob.rdy && rob.cdb_valid && busy[rob.cdb_tag] && !commit_flush;
    end

    assign rob.issue_ready        = issue_ok;
    assign rob.issue_tag          = tail;
    assign rob.set_reorder        = fire && rob.issue_has_rd && (rob.issue_rd != 5'd0);
    assign rob.set_reorder_number = rob.issue_rd;
    assign rob.set_reorder_entry  = tail;
    assign rob.query_ready        = busy[rob.query_tag] && ready[rob.query_tag];
    assign rob.query_value        = value[rob.query_tag];

    // Pointers, occupancy and per-entry busy/ready flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy  <= '0;
            ready <= '0;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (commit_flush) begin
            busy  <= '0;
            ready <= '0;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (rob.rdy) begin
            if (cdb_accept) begin
                ready[rob.cdb_tag] <= 1'b1;
            end
            if (fire) begin
                busy[tail]  <= 1'b1;
                ready[tail] <= 1'b0;
                tail        <= tail + PTR_ONE;
            end
            if (commit_fire) begin
                busy[head] <= 1'b0;
                head       <= head + PTR_ONE;
            end
            case ({fire, commit_fire})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Entry payload captured at issue and at CDB completion.
    // NOTE: the payload arrays have no reset; busy/ready are reset and gate every
    // use of them, so clearing wide storage would buy nothing.
    always_ff @(posedge clk) begin
        if (fire) begin
            has_rd[tail]    <= rob.issue_has_rd;
            rd[tail]        <= rob.issue_rd;
            is_branch[tail] <= rob.issue_is_branch;
        end
        if (cdb_accept) begin
            value[rob.cdb_tag]      <= rob.cdb_value;
            mispredict[rob.cdb_tag] <= rob.cdb_mispredict;
            target[rob.cdb_tag]     <= rob.cdb_target;
        end
    end

    // Registered commit and flush outputs, one cycle after the retiring edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rob.write_enable <= 1'b0;
            rob.write_addr   <= '0;
            rob.write_data   <= '0;
            rob.commit_tag   <= '0;
            rob.flush        <= 1'b0;
            rob.flush_pc     <= '0;
        end else begin
            rob.write_enable <= commit_fire && has_rd[head] && (rd[head] != 5'd0);
            rob.flush        <= commit_flush;
            if (commit_fire) begin
                rob.write_addr <= rd[head];
                rob.write_data <= value[head];
                rob.commit_tag <= head;
            end
            if (commit_flush) begin
                rob.flush_pc <= target[head];
            end
        end
    end
endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed scenarios plus a randomized
// run against a queue-of-entries reference model.
module tb_reorder_buffer;
    typedef struct {
        int        tag;
        bit        has_rd;
        bit [4:0]  rd;
        bit        is_branch;
        bit        done;
        bit [31:0] value;
        bit        mis;
        bit [31:0] target;
    } entry_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;

    // Reference model: live entries oldest-first, next tag to hand out, and
    // the registered outputs expected after the most recent edge.
    entry_t    q[$];
    int        next_tag = 0;
    bit        m_we, m_flush;
    bit [4:0]  m_waddr;
    bit [31:0] m_wdata, m_fpc;
    bit [3:0]  m_ctag;

    reorder_buffer_if #(.ENTRY_SIZE(4)) bus ();
    reorder_buffer #(.ROB_SIZE(16), .ENTRY_SIZE(4)) dut (.clk(clk), .rst(rst), .rob(bus));

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic int find_tag(input int t);
        foreach (q[i]) if (q[i].tag == t) return i;
        return -1;
    endfunction

    function automatic bit m_commit();
        return bus.rdy && (q.size() > 0) && q[0].done;
    endfunction

    function automatic bit m_flushing();
        return m_commit() && q[0].is_branch && q[0].mis;
    endfunction

    function automatic bit m_issue_ready();
        return bus.rdy && (q.size() < 16) && !m_flushing();
    endfunction

    function automatic bit m_set();
        return bus.issue_valid && m_issue_ready() && bus.issue_has_rd && (bus.issue_rd != 5'd0);
    endfunction

    function automatic bit m_query_ready(input int t);
        int k;
        k = find_tag(t);
        return (k >= 0) && q[k].done;
    endfunction

    function automatic bit [31:0] m_query_value(input int t);
        int k;
        k = find_tag(t);
        return (k >= 0) ? q[k].value : 32'd0;
    endfunction

    // Advance the model by one clock edge using the inputs held across it.
    task automatic model_step();
        bit     c, f, fire;
        int     k;
        entry_t e;
        c    = m_commit();
        f    = m_flushing();
        fire = bus.issue_valid && m_issue_ready();
        m_we    = 1'b0;
        m_flush = 1'b0;
        e       = '{default: 0};
        if (c) begin
            e       = q[0];
            m_we    = e.has_rd && (e.rd != 5'd0);
            m_waddr = e.rd;
            m_wdata = e.value;
            m_ctag  = 4'(e.tag);
        end
        if (f) begin
            m_flush  = 1'b1;
            m_fpc    = e.target;
            q.delete();
            next_tag = 0;
        end else begin
            if (bus.rdy && bus.cdb_valid) begin
                k = find_tag(int'(bus.cdb_tag));
                if (k >= 0) begin
                    q[k].done   = 1'b1;
                    q[k].value  = bus.cdb_value;
                    q[k].mis    = bus.cdb_mispredict;
                    q[k].target = bus.cdb_target;
                end
            end
            if (c) void'(q.pop_front());
            if (fire) begin
                e           = '{default: 0};
                e.tag       = next_tag;
                e.has_rd    = bus.issue_has_rd;
                e.rd        = bus.issue_rd;
                e.is_branch = bus.issue_is_branch;
                q.push_back(e);
                next_tag = (next_tag + 1) % 16;
            end
        end
    endtask

    task automatic model_reset();
        q.delete();
        next_tag = 0;
        m_we = 1'b0; m_flush = 1'b0; m_waddr = '0; m_wdata = '0; m_ctag = '0; m_fpc = '0;
    endtask

    task automatic idle_inputs();
        bus.rdy = 1'b1;
        bus.issue_valid = 1'b0; bus.issue_has_rd = 1'b0; bus.issue_rd = '0; bus.issue_is_branch = 1'b0;
        bus.cdb_valid = 1'b0; bus.cdb_tag = '0; bus.cdb_value = '0; bus.cdb_mispredict = 1'b0;
        bus.cdb_target = '0; bus.query_tag = '0;
    endtask

    task automatic set_issue(input bit has, input bit [4:0] r, input bit br);
        bus.issue_valid = 1'b1; bus.issue_has_rd = has; bus.issue_rd = r; bus.issue_is_branch = br;
    endtask

    task automatic set_cdb(input bit [3:0] t, input bit [31:0] v, input bit mis, input bit [31:0] tgt);
        bus.cdb_valid = 1'b1; bus.cdb_tag = t; bus.cdb_value = v; bus.cdb_mispredict = mis; bus.cdb_target = tgt;
    endtask

    // One clock: model follows the edge, returns at the next falling edge.
    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        model_reset();
        #2;
        checks++;
        if ({bus.write_enable, bus.flush, bus.write_addr, bus.write_data, bus.commit_tag, bus.flush_pc} !== '0)
            begin errors++; $display("FAIL reset_outputs: got we=%b fl=%b wa=%0d wd=%h ct=%0d pc=%h want all 0",
                bus.write_enable, bus.flush, bus.write_addr, bus.write_data, bus.commit_tag, bus.flush_pc); end
        checks++;
        if ({bus.issue_ready, bus.issue_tag, bus.query_ready} !== {1'b1, 4'd0, 1'b0})
            begin errors++; $display("FAIL reset_issue: got rdy=%b tag=%0d qr=%b want 1 0 0",
                bus.issue_ready, bus.issue_tag, bus.query_ready); end
        set_issue(1'b1, 5'd3, 1'b0);
        @(posedge clk); #1;
        checks++;
        if (bus.issue_tag !== 4'd0)
            begin errors++; $display("FAIL reset_hold: got tag=%0d want 0", bus.issue_tag); end
        idle_inputs();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_basic();
        apply_reset();
        set_issue(1'b1, 5'd5, 1'b0); #1;
        checks++;
        if ({bus.set_reorder, bus.set_reorder_number, bus.set_reorder_entry, bus.issue_tag} !== {1'b1, 5'd5, 4'd0, 4'd0})
            begin errors++; $display("FAIL basic_set_reorder: got %b %0d %0d tag=%0d want 1 5 0 0",
                bus.set_reorder, bus.set_reorder_number, bus.set_reorder_entry, bus.issue_tag); end
        cycle();
        idle_inputs();
        set_cdb(4'd0, 32'h1234, 1'b0, 32'd0); #1;
        checks++;
        if (bus.query_ready !== 1'b0)
            begin errors++; $display("FAIL basic_query_early: got %b want 0", bus.query_ready); end
        cycle();
        idle_inputs(); #1;
        checks++;
        if ({bus.query_ready, bus.query_value, bus.write_enable} !== {1'b1, 32'h1234, 1'b0})
            begin errors++; $display("FAIL basic_query: got qr=%b qv=%h we=%b want 1 1234 0",
                bus.query_ready, bus.query_value, bus.write_enable); end
        cycle();
        checks++;
        if ({bus.write_enable, bus.write_addr, bus.write_data, bus.commit_tag} !== {1'b1, 5'd5, 32'h1234, 4'd0})
            begin errors++; $display("FAIL basic_commit: got we=%b wa=%0d wd=%h ct=%0d want 1 5 1234 0",
                bus.write_enable, bus.write_addr, bus.write_data, bus.commit_tag); end
        cycle();
        checks++;
        if (bus.write_enable !== 1'b0)
            begin errors++; $display("FAIL basic_we_pulse: got %b want 0", bus.write_enable); end
    endtask

    task automatic test_full();
        apply_reset();
        for (int i = 0; i < 16; i++) begin
            set_issue(1'b1, 5'(i + 1), 1'b0); #1;
            checks++;
            if ({bus.issue_ready, bus.issue_tag} !== {1'b1, 4'(i)})
                begin errors++; $display("FAIL full_fill_%0d: got rdy=%b tag=%0d want 1 %0d",
                    i, bus.issue_ready, bus.issue_tag, i); end
            cycle();
        end
        set_issue(1'b1, 5'd20, 1'b0); #1;
        checks++;
        if ({bus.issue_ready, bus.set_reorder} !== 2'b00)
            begin errors++; $display("FAIL full_stall: got rdy=%b set=%b want 0 0", bus.issue_ready, bus.set_reorder); end
        set_cdb(4'd0, 32'hA0, 1'b0, 32'd0);
        cycle();
        bus.cdb_valid = 1'b0; #1;
        checks++;
        if (bus.issue_ready !== 1'b0)
            begin errors++; $display("FAIL full_no_bypass: got rdy=%b want 0", bus.issue_ready); end
        cycle();
        #1;
        checks++;
        if ({bus.write_enable, bus.write_addr, bus.write_data, bus.commit_tag} !== {1'b1, 5'd1, 32'hA0, 4'd0})
            begin errors++; $display("FAIL full_commit: got we=%b wa=%0d wd=%h ct=%0d want 1 1 a0 0",
                bus.write_enable, bus.write_addr, bus.write_data, bus.commit_tag); end
        checks++;
        if ({bus.issue_ready, bus.issue_tag} !== {1'b1, 4'd0})
            begin errors++; $display("FAIL full_reopen: got rdy=%b tag=%0d want 1 0", bus.issue_ready, bus.issue_tag); end
        cycle();
        idle_inputs(); #1;
        checks++;
        if (bus.issue_ready !== 1'b0)
            begin errors++; $display("FAIL full_refill: got rdy=%b want 0", bus.issue_ready); end
    endtask

    task automatic test_out_of_order();
        int order[3] = '{2, 1, 0};
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            set_issue(1'b1, 5'(i + 1), 1'b0);
            cycle();
        end
        idle_inputs();
        foreach (order[k]) begin
            set_cdb(4'(order[k]), 32'h100 + 32'(order[k]), 1'b0, 32'd0);
            cycle();
            checks++;
            if (bus.write_enable !== 1'b0)
                begin errors++; $display("FAIL ooo_early_commit_%0d: got we=%b want 0", k, bus.write_enable); end
        end
        idle_inputs();
        for (int j = 0; j < 3; j++) begin
            cycle();
            checks++;
            if ({bus.write_enable, bus.commit_tag, bus.write_addr, bus.write_data} !== {1'b1, 4'(j), 5'(j + 1), 32'h100 + 32'(j)})
                begin errors++; $display("FAIL ooo_commit_%0d: got we=%b ct=%0d wa=%0d wd=%h want 1 %0d %0d %h",
                    j, bus.write_enable, bus.commit_tag, bus.write_addr, bus.write_data, j, j + 1, 32'h100 + j); end
        end
    endtask

    task automatic test_mispredict();
        apply_reset();
        for (int i = 0; i < 7; i++) begin
            set_issue(1'b1, (i == 3) ? 5'd31 : 5'(i + 8), i == 3);
            cycle();
        end
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            set_cdb(4'(i), (i == 3) ? 32'h44 : 32'(i * 3), i == 3, (i == 3) ? 32'h80 : 32'h0);
            cycle();
        end
        idle_inputs();
        set_issue(1'b1, 5'd2, 1'b0); #1;
        checks++;
        if ({bus.issue_ready, bus.set_reorder} !== 2'b00)
            begin errors++; $display("FAIL mp_issue_refused: got rdy=%b set=%b want 0 0", bus.issue_ready, bus.set_reorder); end
        cycle();
        checks++;
        if ({bus.flush, bus.flush_pc, bus.write_enable, bus.write_addr, bus.write_data, bus.commit_tag}
                !== {1'b1, 32'h80, 1'b1, 5'd31, 32'h44, 4'd3})
            begin errors++; $display("FAIL mp_flush: got fl=%b pc=%h we=%b wa=%0d wd=%h ct=%0d want 1 80 1 31 44 3",
                bus.flush, bus.flush_pc, bus.write_enable, bus.write_addr, bus.write_data, bus.commit_tag); end
        set_cdb(4'd5, 32'hDEAD, 1'b0, 32'd0);
        bus.query_tag = 4'd4; #1;
        checks++;
        if ({bus.issue_ready, bus.issue_tag, bus.set_reorder_entry, bus.query_ready} !== {1'b1, 4'd0, 4'd0, 1'b0})
            begin errors++; $display("FAIL mp_restart: got rdy=%b tag=%0d ent=%0d qr=%b want 1 0 0 0",
                bus.issue_ready, bus.issue_tag, bus.set_reorder_entry, bus.query_ready); end
        cycle();
        bus.cdb_valid = 1'b0;
        bus.query_tag = 4'd5; #1;
        checks++;
        if ({bus.flush, bus.issue_tag, bus.query_ready} !== {1'b0, 4'd1, 1'b0})
            begin errors++; $display("FAIL mp_after: got fl=%b tag=%0d qr=%b want 0 1 0",
                bus.flush, bus.issue_tag, bus.query_ready); end
        cycle();
    endtask

    task automatic test_no_rd();
        apply_reset();
        set_issue(1'b1, 5'd0, 1'b0); #1;
        checks++;
        if (bus.set_reorder !== 1'b0)
            begin errors++; $display("FAIL nord_rd0_set: got %b want 0", bus.set_reorder); end
        cycle();
        set_issue(1'b0, 5'd7, 1'b0); #1;
        checks++;
        if (bus.set_reorder !== 1'b0)
            begin errors++; $display("FAIL nord_nohas_set: got %b want 0", bus.set_reorder); end
        cycle();
        set_issue(1'b1, 5'd9, 1'b0); #1;
        checks++;
        if ({bus.set_reorder, bus.set_reorder_entry} !== {1'b1, 4'd2})
            begin errors++; $display("FAIL nord_third_set: got %b %0d want 1 2", bus.set_reorder, bus.set_reorder_entry); end
        cycle();
        idle_inputs();
        for (int t = 0; t < 3; t++) begin
            set_cdb(4'(t), 32'h50 + 32'(t), 1'b0, 32'd0);
            cycle();
            if (t > 0) begin
                checks++;
                if (bus.write_enable !== 1'b0)
                    begin errors++; $display("FAIL nord_commit_%0d: got we=%b want 0", t - 1, bus.write_enable); end
            end
        end
        idle_inputs();
        cycle();
        checks++;
        if ({bus.write_enable, bus.commit_tag, bus.write_addr, bus.write_data} !== {1'b1, 4'd2, 5'd9, 32'h52})
            begin errors++; $display("FAIL nord_head_adv: got we=%b ct=%0d wa=%0d wd=%h want 1 2 9 52",
                bus.write_enable, bus.commit_tag, bus.write_addr, bus.write_data); end
    endtask

    task automatic test_pause();
        apply_reset();
        set_issue(1'b1, 5'd4, 1'b0);
        cycle();
        idle_inputs();
        set_cdb(4'd0, 32'h55, 1'b0, 32'd0);
        cycle();
        set_issue(1'b1, 5'd6, 1'b0);
        set_cdb(4'd0, 32'h99, 1'b0, 32'd0);
        bus.rdy = 1'b0;
        for (int p = 0; p < 3; p++) begin
            #1;
            checks++;
            if ({bus.issue_ready, bus.set_reorder} !== 2'b00)
                begin errors++; $display("FAIL pause_issue_%0d: got rdy=%b set=%b want 0 0", p, bus.issue_ready, bus.set_reorder); end
            cycle();
            checks++;
            if ({bus.write_enable, bus.flush} !== 2'b00)
                begin errors++; $display("FAIL pause_commit_%0d: got we=%b fl=%b want 0 0", p, bus.write_enable, bus.flush); end
        end
        idle_inputs();
        cycle();
        checks++;
        if ({bus.write_enable, bus.write_addr, bus.write_data, bus.commit_tag} !== {1'b1, 5'd4, 32'h55, 4'd0})
            begin errors++; $display("FAIL pause_resume: got we=%b wa=%0d wd=%h ct=%0d want 1 4 55 0",
                bus.write_enable, bus.write_addr, bus.write_data, bus.commit_tag); end
        set_issue(1'b1, 5'd7, 1'b0);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({bus.write_enable, bus.flush, bus.write_addr, bus.write_data, bus.commit_tag, bus.flush_pc, bus.issue_tag} !== '0)
            begin errors++; $display("FAIL pause_async_reset: got we=%b wa=%0d wd=%h ct=%0d tag=%0d want all 0",
                bus.write_enable, bus.write_addr, bus.write_data, bus.commit_tag, bus.issue_tag); end
        idle_inputs();
        @(negedge clk);
        rst = 1'b1;
        set_issue(1'b1, 5'd8, 1'b0); #1;
        checks++;
        if ({bus.issue_ready, bus.issue_tag} !== {1'b1, 4'd0})
            begin errors++; $display("FAIL pause_post_reset: got rdy=%b tag=%0d want 1 0", bus.issue_ready, bus.issue_tag); end
        cycle();
        idle_inputs();
    endtask

    task automatic test_random();
        int qt;
        apply_reset();
        for (int n = 0; n < 800; n++) begin
            bus.rdy             = ($urandom_range(0, 9) != 0);
            bus.issue_valid     = ($urandom_range(0, 9) < 6);
            bus.issue_has_rd    = ($urandom_range(0, 3) != 0);
            bus.issue_rd        = 5'($urandom);
            bus.issue_is_branch = ($urandom_range(0, 4) == 0);
            bus.cdb_valid       = 1'($urandom);
            if (q.size() > 0 && $urandom_range(0, 3) != 0)
                bus.cdb_tag = 4'(q[$urandom_range(0, q.size() - 1)].tag);
            else
                bus.cdb_tag = 4'($urandom);
            bus.cdb_value      = $urandom;
            bus.cdb_mispredict = ($urandom_range(0, 3) == 0);
            bus.cdb_target     = $urandom;
            bus.query_tag      = 4'($urandom);
            qt = int'(bus.query_tag);
            #1;
            checks++;
            if ({bus.issue_ready, bus.issue_tag} !== {m_issue_ready(), 4'(next_tag)})
                begin errors++; $display("FAIL rand_issue @%0d: got rdy=%b tag=%0d want %b %0d",
                    n, bus.issue_ready, bus.issue_tag, m_issue_ready(), next_tag); end
            checks++;
            if (bus.set_reorder !== m_set())
                begin errors++; $display("FAIL rand_set @%0d: got %b want %b", n, bus.set_reorder, m_set()); end
            if (m_set()) begin
                checks++;
                if ({bus.set_reorder_number, bus.set_reorder_entry} !== {bus.issue_rd, 4'(next_tag)})
                    begin errors++; $display("FAIL rand_set_fields @%0d: got %0d %0d want %0d %0d",
                        n, bus.set_reorder_number, bus.set_reorder_entry, bus.issue_rd, next_tag); end
            end
            checks++;
            if (bus.query_ready !== m_query_ready(qt))
                begin errors++; $display("FAIL rand_query @%0d: got %b want %b (tag %0d)", n, bus.query_ready, m_query_ready(qt), qt); end
            if (m_query_ready(qt)) begin
                checks++;
                if (bus.query_value !== m_query_value(qt))
                    begin errors++; $display("FAIL rand_query_value @%0d: got %h want %h", n, bus.query_value, m_query_value(qt)); end
            end
            cycle();
            checks++;
            if ({bus.write_enable, bus.flush} !== {m_we, m_flush})
                begin errors++; $display("FAIL rand_pulses @%0d: got we=%b fl=%b want %b %b",
                    n, bus.write_enable, bus.flush, m_we, m_flush); end
            if (m_we) begin
                checks++;
                if ({bus.write_addr, bus.write_data, bus.commit_tag} !== {m_waddr, m_wdata, m_ctag})
                    begin errors++; $display("FAIL rand_write @%0d: got %0d %h %0d want %0d %h %0d",
                        n, bus.write_addr, bus.write_data, bus.commit_tag, m_waddr, m_wdata, m_ctag); end
            end
            if (m_flush) begin
                checks++;
                if (bus.flush_pc !== m_fpc)
                    begin errors++; $display("FAIL rand_flush_pc @%0d: got %h want %h", n, bus.flush_pc, m_fpc); end
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_out_of_order();
        test_mispredict();
        test_no_rd();
        test_pause();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
